wb_port_arbiter: RTL

- Shares the single register-file write port (reg_wen / reg_waddr / reg_wdata) between two writeback sources.
  - Port 0: in-order pipeline result (ALU/MEM stage).
  - Port 1: long-latency unit result (LSU miss / mul-div).
- Keeps a 32-entry pending-write scoreboard for port-1 destinations, so decode can stall on RAW hazards.
- Sits between the EX/MEM stages and the register file. Outputs are registered.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_port_arbiter_if.sv | 52 +++++
 rtl/wb_scoreboard.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and writeback source tags
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic WB_SRC_PIPE = 1'b0;
    localparam logic WB_SRC_LU   = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback ports, decode query and register-file port bundle
interface wb_port_arbiter_if
    import wb_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
);

    logic          p0_valid;
    logic          p0_ready;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;

    logic          p1_valid;
    logic          p1_ready;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;

    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          rs1_busy;
    logic          rs2_busy;

    logic          reg_wen;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;

    // Requesters, decode and the register file side
    modport master (
        output p0_valid, p0_addr, p0_data,
        input  p0_ready,
        output p1_valid, p1_addr, p1_data,
        input  p1_ready,
        output iss_valid, iss_rd, rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  reg_wen, reg_waddr, reg_wdata
    );

    // The arbiter
    modport slave (
        input  p0_valid, p0_addr, p0_data,
        output p0_ready,
        input  p1_valid, p1_addr, p1_data,
        output p1_ready,
        input  iss_valid, iss_rd, rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output reg_wen, reg_waddr, reg_wdata
    );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending long-latency write tracker with two decode query ports
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Clear first so a same-index issue in the same edge keeps the register busy
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Query muxes; x0 never reads busy since bit 0 is held low
    always_comb begin
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-source register-file write port arbiter with starvation guard
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = REG_AW,
    parameter int DW           = REG_DW
) (
    input  logic                clk,
    input  logic                rst,
    wb_port_arbiter_if.slave    bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    starve_cnt;
    logic          grant0;
    logic          grant1;
    logic          force1;
    logic          wen_q;
    logic          src_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          wen_out;

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        force1 = (starve_cnt == LIMIT);
        grant1 = !rst && bus.p1_valid && (!bus.p0_valid || force1);
        grant0 = !rst && bus.p0_valid && !grant1;
    end

    assign bus.p0_ready = grant0;
    assign bus.p1_ready = grant1;

    // Starvation counter: counts consecutive lost cycles of port 1
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!bus.p1_valid || grant1) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Output register; address/data hold when idle, x0 grants complete without a write
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            src_q   <= WB_SRC_PIPE;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (grant0) begin
            wen_q   <= (bus.p0_addr != '0);
            src_q   <= WB_SRC_PIPE;
            waddr_q <= bus.p0_addr;
            wdata_q <= bus.p0_data;
        end else if (grant1) begin
            wen_q   <= (bus.p1_addr != '0);
            src_q   <= WB_SRC_LU;
            waddr_q <= bus.p1_addr;
            wdata_q <= bus.p1_data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    // A reset in the write cycle suppresses the commit so a pending grant is dropped
    assign wen_out       = wen_q && !rst;
    assign bus.reg_wen   = wen_out;
    assign bus.reg_waddr = waddr_q;
    assign bus.reg_wdata = wdata_q;

    wb_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.iss_valid && (bus.iss_rd != '0)),
        .set_idx  (bus.iss_rd),
        .clr_en   (wen_out && (src_q == WB_SRC_LU)),
        .clr_idx  (waddr_q),
        .rs1_addr (bus.rs1_addr),
        .rs2_addr (bus.rs2_addr),
        .rs1_busy (bus.rs1_busy),
        .rs2_busy (bus.rs2_busy)
    );

endmodule
